stamp2time: RTL and testbench

- Converts a 64-bit Unix timestamp into packed-BCD calendar date and time fields. The timestamp is seconds since 1970-01-01 00:00:00 UTC.
- Sits between the free-running seconds counter and the display/formatting logic of the digital clock.
- Multi-cycle iterative converter that runs continuously. It re-samples the counter at the start of every conversion and updates all outputs atomically at the end.

---
 rtl/stamp2time.sv | 216 +++++++++++++++++++++
 tb/tb_stamp2time.sv | 125 ++++++++++++
 2 files changed

// File: rtl/stamp2time.sv
// Iterative Unix-timestamp to packed-BCD calendar converter.
// Free-running: latch counter, divide into days/seconds, walk years and months, then BCD-encode.
module stamp2time (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] counter,
  output logic [15:0] year_bcd,
  output logic [7:0]  month_bcd,
  output logic [7:0]  day_bcd,
  output logic [7:0]  hour_bcd,
  output logic [7:0]  minute_bcd,
  output logic [7:0]  second_bcd
);

  localparam logic [63:0] MAX_STAMP = 64'd253402300799;
  localparam logic [17:0] SEC_DAY   = 18'd86400;

  typedef enum logic [2:0] {
    S_LOAD, S_DIVDAY, S_TOD, S_YEAR, S_MONTH, S_BCD, S_UPDATE
  } state_t;

  state_t state_q, state_d;

  logic [63:0]      num_q, num_d;
  logic [16:0]      rem_q, rem_d;
  logic [6:0]       step_q, step_d;
  logic [4:0]       hour_q, hour_d;
  logic [5:0]       min_q, min_d;
  logic [31:0]      day_q, day_d;
  logic [13:0]      year_q, year_d;
  logic [3:0]       mon_q, mon_d;
  logic [5:0][13:0] bin_q, bin_d;
  logic [15:0]      ybcd_q, ybcd_d;
  logic [4:0][7:0]  fbcd_q, fbcd_d;

  logic [15:0] year_o_q;
  logic [7:0]  month_o_q, day_o_q, hour_o_q, minute_o_q, second_o_q;

  function automatic logic is_leap(input logic [13:0] y);
    return (y[1:0] == 2'd0) && (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
  endfunction

  function automatic logic [31:0] ylen(input logic [13:0] y);
    return is_leap(y) ? 32'd366 : 32'd365;
  endfunction

  function automatic logic [31:0] mlen(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                      mlen = leap ? 32'd29 : 32'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   mlen = 32'd30;
      default:                   mlen = 32'd31;
    endcase
  endfunction

  function automatic logic [15:0] dd_adj16(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  function automatic logic [7:0] dd_adj8(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    for (int i = 0; i < 2; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst_n) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:   state_d = S_DIVDAY;
      S_DIVDAY: if (step_q == 7'd63) state_d = S_TOD;
      S_TOD:    if (step_q == 7'd10) state_d = S_YEAR;
      S_YEAR:   if (day_q < ylen(year_q)) state_d = S_MONTH;
      S_MONTH:  if (day_q < mlen(mon_q, is_leap(year_q))) state_d = S_BCD;
      S_BCD:    if (step_q == 7'd13) state_d = S_UPDATE;
      S_UPDATE: state_d = S_LOAD;
      default:  state_d = S_LOAD;
    endcase
  end

  always_comb begin
    logic [17:0] trial;
    logic [21:0] div;
    logic [2:0]  k;
    num_d  = num_q;
    rem_d  = rem_q;
    hour_d = hour_q;
    min_d  = min_q;
    day_d  = day_q;
    year_d = year_q;
    mon_d  = mon_q;
    bin_d  = bin_q;
    ybcd_d = ybcd_q;
    fbcd_d = fbcd_q;
    trial  = '0;
    div    = '0;
    k      = '0;
    step_d = (state_d != state_q) ? 7'd0 : step_q + 7'd1;
    case (state_q)
      S_LOAD: begin
        num_d  = (counter > MAX_STAMP) ? MAX_STAMP : counter;
        rem_d  = '0;
        hour_d = '0;
        min_d  = '0;
      end
      S_DIVDAY: begin
        trial = {rem_q, num_q[63]};
        if (trial >= SEC_DAY) begin
          rem_d = 17'(trial - SEC_DAY);
          num_d = {num_q[62:0], 1'b1};
        end else begin
          rem_d = trial[16:0];
          num_d = {num_q[62:0], 1'b0};
        end
      end
      S_TOD: begin
        // Hours take quotient bits 4..0 of /3600, then minutes take bits 5..0 of /60.
        day_d  = num_q[31:0];
        year_d = 14'd1970;
        mon_d  = 4'd1;
        if (step_q < 7'd5) begin
          k   = 3'd4 - step_q[2:0];
          div = 22'd3600 << k;
          if ({5'd0, rem_q} >= div) begin
            rem_d     = 17'({5'd0, rem_q} - div);
            hour_d[k] = 1'b1;
          end
        end else begin
          k   = 3'(4'd10 - step_q[3:0]);
          div = 22'd60 << k;
          if ({5'd0, rem_q} >= div) begin
            rem_d    = 17'({5'd0, rem_q} - div);
            min_d[k] = 1'b1;
          end
        end
      end
      S_YEAR: begin
        if (day_q >= ylen(year_q)) begin
          day_d  = day_q - ylen(year_q);
          year_d = year_q + 14'd1;
        end
      end
      S_MONTH: begin
        if (day_q >= mlen(mon_q, is_leap(year_q))) begin
          day_d = day_q - mlen(mon_q, is_leap(year_q));
          mon_d = mon_q + 4'd1;
        end else begin
          bin_d[0] = year_q;
          bin_d[1] = {10'd0, mon_q};
          bin_d[2] = {9'd0, day_q[4:0] + 5'd1};
          bin_d[3] = {9'd0, hour_q};
          bin_d[4] = {8'd0, min_q};
          bin_d[5] = {8'd0, rem_q[5:0]};
          ybcd_d   = '0;
          fbcd_d   = '0;
        end
      end
      S_BCD: begin
        {ybcd_d, bin_d[0]} = {dd_adj16(ybcd_q), bin_q[0]} << 1;
        for (int i = 0; i < 5; i++)
          {fbcd_d[i], bin_d[i+1]} = {dd_adj8(fbcd_q[i]), bin_q[i+1]} << 1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    num_q  <= num_d;
    rem_q  <= rem_d;
    step_q <= step_d;
    hour_q <= hour_d;
    min_q  <= min_d;
    day_q  <= day_d;
    year_q <= year_d;
    mon_q  <= mon_d;
    bin_q  <= bin_d;
    ybcd_q <= ybcd_d;
    fbcd_q <= fbcd_d;
  end

  // All six fields commit together so a half-updated date is never visible.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      year_o_q   <= 16'h1970;
      month_o_q  <= 8'h01;
      day_o_q    <= 8'h01;
      hour_o_q   <= 8'h00;
      minute_o_q <= 8'h00;
      second_o_q <= 8'h00;
    end else if (state_q == S_UPDATE) begin
      year_o_q   <= ybcd_q;
      month_o_q  <= fbcd_q[0];
      day_o_q    <= fbcd_q[1];
      hour_o_q   <= fbcd_q[2];
      minute_o_q <= fbcd_q[3];
      second_o_q <= fbcd_q[4];
    end
  end

  assign year_bcd   = year_o_q;
  assign month_bcd  = month_o_q;
  assign day_bcd    = day_o_q;
  assign hour_bcd   = hour_o_q;
  assign minute_bcd = minute_o_q;
  assign second_bcd = second_o_q;

endmodule

// File: tb/tb_stamp2time.sv
// Bench for stamp2time: table of timestamps with expected BCD dates, plus reset sequences.
module tb_stamp2time;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] counter;
  logic [15:0] year_bcd;
  logic [7:0]  month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd;

  stamp2time dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .counter    (counter),
    .year_bcd   (year_bcd),
    .month_bcd  (month_bcd),
    .day_bcd    (day_bcd),
    .hour_bcd   (hour_bcd),
    .minute_bcd (minute_bcd),
    .second_bcd (second_bcd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] cnt;
    logic [55:0] exp;
    int          budget;
    string       name;
  } vec_t;

  vec_t        vecs[10];
  logic [55:0] sb_q[$];
  logic [55:0] prev;
  logic [55:0] outs;
  int          total = 0;
  int          bad   = 0;

  assign outs = {year_bcd, month_bcd, day_bcd, hour_bcd, minute_bcd, second_bcd};

  function automatic logic [55:0] mk(input logic [15:0] y, input logic [7:0] mo, input logic [7:0] d,
                                     input logic [7:0] h, input logic [7:0] mi, input logic [7:0] s);
    return {y, mo, d, h, mi, s};
  endfunction

  task automatic chk(input string nm, input logic [55:0] act, input logic [55:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, req);
    end
  endtask

  // Drive a new timestamp, wait for the result, and verify every intermediate sample is old or new.
  task automatic run_vec(input vec_t v);
    logic [55:0] got, exp;
    bit          mixed;
    int          cyc;
    sb_q.push_back(v.exp);
    counter = v.cnt;
    mixed   = 1'b0;
    cyc     = 0;
    got     = outs;
    while (got !== v.exp && cyc < v.budget) begin
      @(negedge clk);
      cyc++;
      got = outs;
      if (got !== v.exp && got !== prev) mixed = 1'b1;
    end
    exp = sb_q.pop_front();
    chk({v.name, "_atomic"}, {55'd0, mixed}, 56'd0);
    chk(v.name, got, exp);
    prev = exp;
  endtask

  localparam logic [55:0] EPOCH = 56'h1970_01_01_00_00_00;

  initial begin
    vec_t v;
    vecs[0] = '{64'd0,                     mk(16'h1970, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00), 600,   "epoch"};
    vecs[1] = '{64'd86399,                 mk(16'h1970, 8'h01, 8'h01, 8'h23, 8'h59, 8'h59), 600,   "day0_end"};
    vecs[2] = '{64'd1698409800,            mk(16'h2023, 8'h10, 8'h27, 8'h12, 8'h30, 8'h00), 600,   "y2023"};
    vecs[3] = '{64'd946684800,             mk(16'h2000, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00), 600,   "y2000"};
    vecs[4] = '{64'd951782400,             mk(16'h2000, 8'h02, 8'h29, 8'h00, 8'h00, 8'h00), 600,   "leap2000"};
    vecs[5] = '{64'd951868800,             mk(16'h2000, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00), 600,   "mar2000"};
    vecs[6] = '{64'd1709251199,            mk(16'h2024, 8'h02, 8'h29, 8'h23, 8'h59, 8'h59), 600,   "leap2024"};
    vecs[7] = '{64'd4107542399,            mk(16'h2100, 8'h02, 8'h28, 8'h23, 8'h59, 8'h59), 600,   "feb2100"};
    vecs[8] = '{64'd4107542400,            mk(16'h2100, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00), 600,   "mar2100"};
    vecs[9] = '{64'hFFFF_FFFF_FFFF_FFFF,   mk(16'h9999, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59), 20000, "saturate"};

    rst_n   = 1'b1;
    counter = 64'd0;
    repeat (3) @(negedge clk);
    chk("reset_vals", outs, EPOCH);
    repeat (5) @(negedge clk);
    chk("reset_hold", outs, EPOCH);
    rst_n = 1'b0;
    prev  = EPOCH;

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    // Reset in the middle of a conversion toward 2023.
    counter = 64'd1698409800;
    repeat (50) @(negedge clk);
    chk("hold_mid_conv", outs, vecs[9].exp);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_mid_conv", outs, EPOCH);
    repeat (4) @(negedge clk);
    chk("reset_mid_hold", outs, EPOCH);
    rst_n = 1'b0;
    prev  = EPOCH;
    v = '{64'd1698409800, mk(16'h2023, 8'h10, 8'h27, 8'h12, 8'h30, 8'h00), 600, "after_reset"};
    run_vec(v);

    // Counter change a few cycles into a conversion.
    repeat (37) @(negedge clk);
    run_vec(vecs[4]);
    repeat (120) @(negedge clk);
    run_vec(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
